// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: two-flop row synchroniser, column scan,
// per-frame single-key decode and frame-level press/release debounce.
module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV = 16'd1000,
    parameter logic [3:0]  DEBOUNCE = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_press
);
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
    localparam logic [3:0] NONE = 4'hF;

    logic [3:0]  sync1_q, sync2_q;
    logic [15:0] div_q, div_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  col_out_q, col_out_d;
    logic        found_q, found_d, multi_q, multi_d;
    logic [3:0]  code_q, code_d;
    state_t      state_q, state_d;
    logic [3:0]  cand_q, cand_d, cnt_q, cnt_d, key_q, key_d;
    logic        key_valid_q, key_valid_d, key_press_q, key_press_d;

    logic        last_slot, frame_end;
    logic [3:0]  lows;
    logic [2:0]  n_low;
    logic [1:0]  row_hit;
    logic        found_acc, multi_acc;
    logic [3:0]  code_acc, frame_result, cnt_inc;

    // Column scan and frame accumulation; the frame result includes the
    // column-3 sample taken in the same cycle as frame_end.
    always_comb begin
        last_slot = (div_q == SCAN_DIV - 16'd1);
        frame_end = last_slot && (col_idx_q == 2'd3);
        lows      = ~sync2_q;
        n_low     = 3'd0;
        row_hit   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            n_low = n_low + {2'b00, lows[i]};
            if (lows[i]) row_hit = 2'(i);
        end
        div_d     = last_slot ? 16'd0 : div_q + 16'd1;
        col_idx_d = last_slot ? col_idx_q + 2'd1 : col_idx_q;
        col_out_d = ~(4'b0001 << col_idx_d);

        found_acc = found_q || (n_low != 3'd0);
        multi_acc = multi_q || (n_low >= 3'd2) || (found_q && (n_low != 3'd0));
        code_acc  = (n_low == 3'd1) ? {row_hit, col_idx_q} : code_q;
        // Reserved code F coincides with NONE, so it needs no special case.
        frame_result = (multi_acc || !found_acc) ? NONE : code_acc;

        found_d = found_q;
        multi_d = multi_q;
        code_d  = code_q;
        if (frame_end) begin
            found_d = 1'b0;
            multi_d = 1'b0;
            code_d  = NONE;
        end else if (last_slot) begin
            found_d = found_acc;
            multi_d = multi_acc;
            code_d  = code_acc;
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        key_press_d = 1'b0;
        cnt_inc     = cnt_q + 4'd1;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_result != NONE) begin
                        cand_d = frame_result;
                        cnt_d  = 4'd1;
                        if (DEBOUNCE == 4'd1) begin
                            state_d     = HELD;
                            key_d       = frame_result;
                            key_valid_d = 1'b1;
                            key_press_d = 1'b1;
                        end else begin
                            state_d = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (frame_result == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEBOUNCE) begin
                            state_d     = HELD;
                            key_d       = cand_q;
                            key_valid_d = 1'b1;
                            key_press_d = 1'b1;
                        end
                    end else if (frame_result == NONE) begin
                        state_d = IDLE;
                    end else begin
                        cand_d = frame_result;
                        cnt_d  = 4'd1;
                    end
                end
                HELD: begin
                    if (frame_result != key_q) begin
                        cnt_d = 4'd1;
                        if (DEBOUNCE == 4'd1) begin
                            state_d     = IDLE;
                            key_d       = NONE;
                            key_valid_d = 1'b0;
                        end else begin
                            state_d = REL_DB;
                        end
                    end
                end
                REL_DB: begin
                    if (frame_result == key_q) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEBOUNCE) begin
                            state_d     = IDLE;
                            key_d       = NONE;
                            key_valid_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            div_q       <= 16'd0;
            col_idx_q   <= 2'd0;
            col_out_q   <= 4'b1110;
            found_q     <= 1'b0;
            multi_q     <= 1'b0;
            code_q      <= NONE;
            state_q     <= IDLE;
            cand_q      <= NONE;
            cnt_q       <= 4'd0;
            key_q       <= NONE;
            key_valid_q <= 1'b0;
            key_press_q <= 1'b0;
        end else begin
            sync1_q     <= row_in;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_out_q   <= col_out_d;
            found_q     <= found_d;
            multi_q     <= multi_d;
            code_q      <= code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_press_q <= key_press_d;
        end
    end

    assign col_out   = col_out_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_press = key_press_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural keypad drives the rows from the set
// of pressed switches; a frame-level run-length model predicts key/key_press.
module tb_keypad_scanner;
    localparam logic [15:0] SD = 16'd4;
    localparam logic [3:0]  DB = 4'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] row_in, col_out, key;
    logic key_valid, key_press;
    logic [15:0] pressed = 16'd0;

    int n_checks = 0;
    int n_pass = 0;
    int press_seen = 0;

    // Frame-level reference state
    logic [3:0] m_key, run_val;
    int run_len, rel_len;
    logic m_press;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  exp_key;
        int          exp_press;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key(key), .key_valid(key_valid), .key_press(key_press)
    );

    // Switch (r,c) shorts row r to column c; bit index is r*4+c.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [3:0] frame_result(input logic [15:0] p);
        if ($countones(p) != 1) return 4'hF;
        for (int k = 0; k < 16; k++) if (p[k]) return 4'(k);
        return 4'hF;
    endfunction

    task automatic model_reset();
        m_key = 4'hF; run_val = 4'hF; run_len = 0; rel_len = 0; m_press = 1'b0;
    endtask

    task automatic model_update(input logic [3:0] r);
        m_press = 1'b0;
        if (m_key == 4'hF) begin
            if (r == 4'hF) run_len = 0;
            else if (run_len > 0 && r == run_val) run_len++;
            else begin run_val = r; run_len = 1; end
            if (run_len == int'(DB)) begin
                m_key = r; m_press = 1'b1; run_len = 0;
            end
        end else begin
            if (r == m_key) rel_len = 0;
            else rel_len++;
            if (rel_len == int'(DB)) begin
                m_key = 4'hF; rel_len = 0; run_len = 0;
            end
        end
    endtask

    // Called at a negedge; leaves rst low at the negedge of cycle 0.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_col", {12'd0, col_out}, 16'hE);
        chk("rst_key", {12'd0, key}, 16'hF);
        chk("rst_valid", {15'd0, key_valid}, 16'd0);
        chk("rst_press", {15'd0, key_press}, 16'd0);
        rst = 1'b0;
        press_seen = 0;
        model_reset();
    endtask

    // One 16-cycle frame with switch set p, starting at the negedge of its first cycle.
    task automatic run_frame(input logic [15:0] p);
        logic [3:0] one, exp_col;
        one = 4'b0001;
        pressed = p;
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(one << (i / 4));
            chk("col_out", {12'd0, col_out}, {12'd0, exp_col});
            if (i != 0) begin
                chk("key_mid", {12'd0, key}, {12'd0, m_key});
                chk("press_mid", {15'd0, key_press}, 16'd0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        model_update(frame_result(p));
        chk("key_end", {12'd0, key}, {12'd0, m_key});
        chk("valid_end", {15'd0, key_valid}, {15'd0, m_key != 4'hF});
        chk("press_end", {15'd0, key_press}, {15'd0, m_press});
        if (key_press) press_seen++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] cur;
        int sel;
        tbl[0] = '{16'h0040, 4'h6, 1};   // row1/col2
        tbl[1] = '{16'h0201, 4'hF, 0};   // (0,0)+(2,1) together
        tbl[2] = '{16'h8000, 4'hF, 0};   // (3,3) reserved
        tbl[3] = '{16'h4000, 4'hE, 1};   // (3,2)
        tbl[4] = '{16'h0000, 4'hF, 0};
        tbl[5] = '{16'h0001, 4'h0, 1};   // (0,0)
        tbl[6] = '{16'h0800, 4'hB, 1};   // (2,3)
        tbl[7] = '{16'h0088, 4'hF, 0};   // two rows, same column

        @(negedge clk);
        do_reset(5);
        for (int v = 0; v < 8; v++) begin
            do_reset(2);
            repeat (4) run_frame(tbl[v].keys);
            chk("tbl_key", {12'd0, key}, {12'd0, tbl[v].exp_key});
            chk("tbl_valid", {15'd0, key_valid}, {15'd0, tbl[v].exp_key != 4'hF});
            chk("tbl_press", 16'(press_seen), 16'(tbl[v].exp_press));
        end

        // Hold code 6 ~100 cycles, then release
        do_reset(2);
        repeat (2) run_frame(16'h0040);
        chk("hold6_early", {12'd0, key}, 16'hF);
        repeat (5) run_frame(16'h0040);
        chk("hold6_key", {12'd0, key}, 16'h6);
        chk("hold6_once", 16'(press_seen), 16'd1);
        repeat (3) run_frame(16'h0000);
        chk("rel6_key", {12'd0, key}, 16'hF);
        chk("rel6_valid", {15'd0, key_valid}, 16'd0);

        // Bounce on (0,0), then settle
        do_reset(2);
        run_frame(16'h0001); run_frame(16'h0000);
        run_frame(16'h0001); run_frame(16'h0000);
        chk("bounce_nopress", 16'(press_seen), 16'd0);
        repeat (3) run_frame(16'h0001);
        chk("bounce_key", {12'd0, key}, 16'h0);
        chk("bounce_press", 16'(press_seen), 16'd1);

        // Roll from key 5 to key A without releasing
        do_reset(2);
        repeat (3) run_frame(16'h0020);
        chk("roll_a", {12'd0, key}, 16'h5);
        repeat (5) run_frame(16'h0400);
        chk("roll_gap", {12'd0, key}, 16'hF);
        chk("roll_gap_press", 16'(press_seen), 16'd1);
        run_frame(16'h0400);
        chk("roll_b", {12'd0, key}, 16'hA);
        chk("roll_b_press", 16'(press_seen), 16'd2);

        // Reset in the middle of press debounce
        do_reset(2);
        repeat (2) run_frame(16'h0020);
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
            chk("mid_press", {15'd0, key_press}, 16'd0);
        end
        do_reset(3);
        repeat (2) run_frame(16'h0020);
        chk("rst_restart_nopress", 16'(press_seen), 16'd0);
        run_frame(16'h0020);
        chk("rst_restart_key", {12'd0, key}, 16'h5);

        // Random switch activity against the model
        do_reset(2);
        cur = 16'd0;
        for (int f = 0; f < 150; f++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 6) cur = 16'd0;
            else if (sel == 7 || sel == 8) cur = 16'd1 << $urandom_range(0, 15);
            else if (sel == 9) cur = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            run_frame(cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
